// File: rtl/pipe_pkg.sv
// Shared defaults, beat layout and bubble control word for the pipeline stage.
// Pure declarations: no latency, no backpressure.
// The NOP control word marks bubbles on the downstream control bus.
package pipe_pkg;
    localparam int CTRL_W_DEF   = 16;
    localparam int DATA_W_DEF   = 32;
    localparam int DIR_W_DEF    = 4;
    localparam int NUM_DATA_DEF = 3;

    localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

    typedef struct packed {
        logic [CTRL_W_DEF-1:0]              ctrl;
        logic [DIR_W_DEF-1:0]               dir;
        logic [NUM_DATA_DEF*DATA_W_DEF-1:0] data;
    } beat_t;
endpackage

// File: rtl/pipe_stage_entry.sv
// One held beat: payload register plus valid bit, with load enable and valid clear.
// Latency: 1 cycle from i_load to o_vld/o_dat. No backpressure of its own.
// Clear beats load and keeps the payload; reset zeroes both.
module pipe_stage_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clr,
    input  logic [W-1:0] i_dat,
    output logic         o_vld,
    output logic [W-1:0] o_dat
);
    logic         r_vld;
    logic [W-1:0] r_dat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_clr) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_dat <= i_dat;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;
endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register (main + skid); PIPE_STAGE_PERF_EN adds stall/bubble counters.
// Latency: 1 cycle when empty; full throughput with out_ready held high.
// Backpressure: in_ready = !skid_valid, registered, no path from out_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DIR_W    = DIR_W_DEF,
    parameter int NUM_DATA = NUM_DATA_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [DIR_W-1:0]           in_dir,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [DIR_W-1:0]           out_dir,
    output logic [NUM_DATA*DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                bubble_cnt
`endif
);
    typedef struct packed {
        logic [CTRL_W-1:0]          ctrl;
        logic [DIR_W-1:0]           dir;
        logic [NUM_DATA*DATA_W-1:0] data;
    } lbeat_t;

    localparam int BEAT_W = $bits(lbeat_t);

    lbeat_t w_in_beat;
    lbeat_t w_main_nxt;
    lbeat_t w_main_beat;
    lbeat_t w_skid_beat;
    logic   w_main_vld;
    logic   w_skid_vld;
    logic   w_accept;
    logic   w_main_take;
    logic   w_main_load;
    logic   w_main_clr;
    logic   w_skid_load;
    logic   w_skid_clr;

    assign w_in_beat = '{ctrl: in_ctrl, dir: in_dir, data: in_data};

    assign in_ready    = rst_n & ~w_skid_vld;
    assign w_accept    = in_valid & in_ready;
    assign w_main_take = ~w_main_vld | out_ready;

    // Skid always drains first so ordering is preserved.
    assign w_main_nxt  = w_skid_vld ? w_skid_beat : w_in_beat;
    assign w_main_load = w_main_take & (w_skid_vld | w_accept);
    assign w_main_clr  = flush | (w_main_take & ~w_skid_vld & ~w_accept);
    assign w_skid_load = w_accept & ~w_main_take;
    assign w_skid_clr  = flush | (w_main_take & w_skid_vld);

    pipe_stage_entry #(.W(BEAT_W)) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_main_load),
        .i_clr  (w_main_clr),
        .i_dat  (w_main_nxt),
        .o_vld  (w_main_vld),
        .o_dat  (w_main_beat)
    );

    pipe_stage_entry #(.W(BEAT_W)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_skid_load),
        .i_clr  (w_skid_clr),
        .i_dat  (w_in_beat),
        .o_vld  (w_skid_vld),
        .o_dat  (w_skid_beat)
    );

    assign out_valid = w_main_vld;
    assign out_ctrl  = w_main_vld ? w_main_beat.ctrl : CTRL_W'(CTRL_NOP);
    assign out_dir   = w_main_beat.dir;
    assign out_data  = w_main_beat.data;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_main_vld && !out_ready && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!w_main_vld && out_ready && r_bubble_cnt != 32'hFFFF_FFFF)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue model of the held beats checked every negedge,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_ctrl = '0;
    logic [3:0]  in_dir = '0;
    logic [95:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_ctrl;
    logic [3:0]  out_dir;
    logic [95:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int tx_idx = 0;
    int rx_idx = 0;
    bit streaming = 1'b0;
    beat_t mq[$];

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_dir    (in_dir),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_dir   (out_dir),
        .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic beat_t mk(input int i);
        beat_t b;
        b.ctrl = 16'h1000 + i[15:0];
        b.dir  = i[3:0];
        b.data = {32'hA000_0000 + i, 32'hB000_0000 ^ i, 32'hC000_0000 + i * 3};
        return b;
    endfunction

    task automatic drive(input beat_t b, input logic v);
        in_valid = v;
        in_ctrl  = b.ctrl;
        in_dir   = b.dir;
        in_data  = b.data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the stage is an ordered queue of at most two beats.
    always @(posedge clk) begin
        bit acc;
        acc = in_valid && rst_n && (mq.size() < 2);
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (acc) mq.push_back(beat_t'{ctrl: in_ctrl, dir: in_dir, data: in_data});
        end
        if (streaming && acc && !flush) tx_idx++;
    end

    always @(negedge clk) begin
        beat_t f;
        f = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid", out_valid, mq.size() > 0);
        chk("in_ready", in_ready, rst_n && (mq.size() < 2));
        chk("out_ctrl", out_ctrl, f.ctrl);
        if (mq.size() > 0) begin
            chk("out_dir", out_dir, f.dir);
            chk("out_data", out_data, f.data);
        end
        if (streaming && out_valid && out_ready) begin
            beat_t e;
            e = mk(rx_idx);
            chk("rx_ctrl", out_ctrl, e.ctrl);
            chk("rx_dir", out_dir, e.dir);
            chk("rx_data", out_data, e.data);
            rx_idx++;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_ctrl", out_ctrl, 16'h0);
        chk("rst_out_dir", out_dir, 4'h0);
        chk("rst_out_data", out_data, 96'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        do_reset();

        // single beat, 1-cycle latency
        b = mk(0);
        b.ctrl = 16'h00A5;
        drive(b, 1'b1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out_ctrl", out_ctrl, 16'h00A5);
        chk("t1_in_ready", in_ready, 1'b1);
        tick();
        chk("t1_drained", out_valid, 1'b0);

        // fill skid, then drain in order
        out_ready = 1'b0;
        drive(mk(1), 1'b1);
        tick();
        drive(mk(2), 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t2_in_ready_full", in_ready, 1'b0);
        chk("t2_head_d1", out_ctrl, 16'h1001);
        out_ready = 1'b1;
        tick();
        chk("t2_head_d2", out_ctrl, 16'h1002);
        chk("t2_in_ready_back", in_ready, 1'b1);
        tick();
        chk("t2_empty", out_valid, 1'b0);

        // flush while full, with out_ready high and an offered beat
        out_ready = 1'b0;
        drive(mk(3), 1'b1);
        tick();
        drive(mk(4), 1'b1);
        tick();
        flush = 1'b1;
        out_ready = 1'b1;
        drive(mk(5), 1'b1);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t3_out_valid", out_valid, 1'b0);
        chk("t3_out_ctrl", out_ctrl, 16'h0);
        tick();
        tick();
        chk("t3_no_stale", out_valid, 1'b0);

        // 100-beat stream with random backpressure
        tx_idx = 0;
        rx_idx = 0;
        streaming = 1'b1;
        for (int cyc = 0; cyc < 3000 && rx_idx < 100; cyc++) begin
            drive(mk(tx_idx), tx_idx < 100);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        streaming = 1'b0;
        chk("t4_rx_count", rx_idx, 100);
        chk("t4_tx_count", tx_idx, 100);
        out_ready = 1'b1;
        tick();

        // reset mid-stream with skid full
        out_ready = 1'b0;
        drive(mk(6), 1'b1);
        tick();
        drive(mk(7), 1'b1);
        tick();
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(mk(8), 1'b1);
        tick();
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_in_ready", in_ready, 1'b0);
        chk("t5_out_ctrl", out_ctrl, 16'h0);
        chk("t5_out_dir", out_dir, 4'h0);
        chk("t5_out_data", out_data, 96'h0);
        rst_n = 1'b1;
        drive(mk(9), 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t5_restart_vld", out_valid, 1'b1);
        chk("t5_restart_ctrl", out_ctrl, 16'h1009);
        tick();
        chk("t5_restart_drain", out_valid, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        do_reset();
        drive(mk(10), 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        chk("perf_stall", stall_cnt, 32'd5);
        chk("perf_bubble", bubble_cnt, 32'd3);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
